// File: rtl/seq_pkg.sv
// Shared constants and state type for the datapath sequencer.
// Holds control codes, ULA codes, opcodes and the FSM state encoding.
package seq_pkg;

  localparam int CLEAR  = 0;
  localparam int LOAD   = 1;
  localparam int HOLD   = 2;
  localparam int SHIFTR = 3;

  localparam int ULA_ADD = 0;
  localparam int ULA_SUB = 1;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AVG  = 2;
  localparam int OP_MOVE = 3;

  typedef enum logic [3:0] {
    RST_CLR = 4'd0,
    IDLE    = 4'd1,
    FETCH_A = 4'd2,
    LOAD_A  = 4'd3,
    COMBINE = 4'd4,
    SHIFT   = 4'd5,
    STORE   = 4'd6,
    DONE    = 4'd7
  } state_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Host <-> sequencer bundle: start/opcode in, control codes and status out.
// master = host side, slave = sequencer side. Optional err under SEQ_OPCODE_ERR_EN.
interface datapath_sequencer_if #(
  parameter int CW  = 4,
  parameter int OPW = 3
);
  logic           start;
  logic [OPW-1:0] opcode;
  logic           busy;
  logic           done;
  logic           in_sel;
  logic [CW-1:0]  tx;
  logic [CW-1:0]  ty;
  logic [CW-1:0]  tz;
  logic [CW-1:0]  tula;
  logic [3:0]     state_dbg;
`ifdef SEQ_OPCODE_ERR_EN
  logic           err;

  modport master (
    output start, opcode,
    input  busy, done, in_sel,
    input  tx, ty, tz, tula,
    input  state_dbg, err
  );
  modport slave (
    input  start, opcode,
    output busy, done, in_sel,
    output tx, ty, tz, tula,
    output state_dbg, err
  );
`else
  modport master (
    output start, opcode,
    input  busy, done, in_sel,
    input  tx, ty, tz, tula,
    input  state_dbg
  );
  modport slave (
    input  start, opcode,
    output busy, done, in_sel,
    output tx, ty, tz, tula,
    output state_dbg
  );
`endif
endinterface

// File: rtl/seq_decode.sv
// Moore output decode: state + latched opcode -> datapath control codes.
// Ports: state, op in; tx/ty/tz/tula, in_sel, busy, done out.
module seq_decode
  import seq_pkg::*;
#(
  parameter int CW  = 4,
  parameter int OPW = 3
) (
  input  state_t         state,
  input  logic [OPW-1:0] op,
  output logic [CW-1:0]  tx,
  output logic [CW-1:0]  ty,
  output logic [CW-1:0]  tz,
  output logic [CW-1:0]  tula,
  output logic           in_sel,
  output logic           busy,
  output logic           done
);

  logic is_sub;
  assign is_sub = (op == OPW'(OP_SUB));

  always_comb begin
    // Unused encodings decode like RST_CLR.
    tx     = CW'(CLEAR);
    ty     = CW'(CLEAR);
    tz     = CW'(CLEAR);
    tula   = CW'(ULA_ADD);
    in_sel = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    unique case (state)
      IDLE: begin
        tx   = CW'(HOLD);
        ty   = CW'(HOLD);
        tz   = CW'(HOLD);
        busy = 1'b0;
      end
      FETCH_A: begin
        tx = CW'(LOAD);
        tz = CW'(HOLD);
      end
      LOAD_A: begin
        tx     = CW'(LOAD);
        ty     = CW'(LOAD);
        tz     = CW'(HOLD);
        in_sel = 1'b1;
      end
      COMBINE: begin
        tx   = CW'(HOLD);
        ty   = CW'(LOAD);
        tz   = CW'(HOLD);
        tula = is_sub ? CW'(ULA_SUB)
                      : CW'(ULA_ADD);
      end
      SHIFT: begin
        tx = CW'(HOLD);
        ty = CW'(SHIFTR);
        tz = CW'(HOLD);
      end
      STORE: begin
        ty = CW'(HOLD);
        tz = CW'(LOAD);
      end
      DONE: begin
        tx   = CW'(HOLD);
        ty   = CW'(HOLD);
        tz   = CW'(HOLD);
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Start/busy/done sequencer for the X/Y/Z/ULA datapath.
// Ports: clock, reset (async high), bus (slave: start, opcode -> codes,
// busy, done, in_sel, state_dbg). SEQ_OPCODE_ERR_EN adds err for opcodes 4-7.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int CW  = 4,
  parameter int OPW = 3
) (
  input logic                  clock,
  input logic                  reset,
  datapath_sequencer_if.slave  bus
);

  state_t         state_q;
  state_t         state_d;
  logic [OPW-1:0] op_q;

`ifdef SEQ_OPCODE_ERR_EN
  logic err_q;
  logic err_d;
  logic op_ok;
  assign op_ok = (bus.opcode < OPW'(4));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RST_CLR;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start)
        op_q <= bus.opcode;
    end
  end

`ifdef SEQ_OPCODE_ERR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign bus.err = err_q;
`endif

  always_comb begin
    state_d = RST_CLR;
`ifdef SEQ_OPCODE_ERR_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      RST_CLR: state_d = IDLE;
      IDLE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = FETCH_A;
`ifdef SEQ_OPCODE_ERR_EN
          // Illegal opcode skips the datapath entirely.
          if (!op_ok) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      FETCH_A: state_d = LOAD_A;
      LOAD_A:
        state_d = (op_q == OPW'(OP_MOVE)) ? STORE : COMBINE;
      COMBINE:
        state_d = (op_q == OPW'(OP_AVG)) ? SHIFT : STORE;
      SHIFT:   state_d = STORE;
      STORE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = RST_CLR;
    endcase
  end

  assign bus.state_dbg = state_q;

  seq_decode #(
    .CW  (CW),
    .OPW (OPW)
  ) u_decode (
    .state  (state_q),
    .op     (op_q),
    .tx     (bus.tx),
    .ty     (bus.ty),
    .tz     (bus.tz),
    .tula   (bus.tula),
    .in_sel (bus.in_sel),
    .busy   (bus.busy),
    .done   (bus.done)
  );

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: model X/Y/Z datapath plus done scoreboard.
// Build with or without SEQ_OPCODE_ERR_EN.
module tb_datapath_sequencer;
  import seq_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  datapath_sequencer_if #(.CW(4), .OPW(3)) sif ();

  datapath_sequencer #(.CW(4), .OPW(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif.slave)
  );

  logic [7:0] opa, opb;
  logic [7:0] xm = 8'h55;
  logic [7:0] ym = 8'h55;
  logic [7:0] zm = 8'h55;

  // Reference datapath driven only by the control codes.
  always @(posedge clock) begin
    case (sif.tx)
      4'd0: xm <= 8'd0;
      4'd1: xm <= sif.in_sel ? opb : opa;
      4'd3: xm <= xm >> 1;
      default: ;
    endcase
    case (sif.ty)
      4'd0: ym <= 8'd0;
      4'd1: ym <= (sif.tula == 4'd1) ? ym - xm : ym + xm;
      4'd3: ym <= ym >> 1;
      default: ;
    endcase
    case (sif.tz)
      4'd0: zm <= 8'd0;
      4'd1: zm <= ym;
      4'd3: zm <= zm >> 1;
      default: ;
    endcase
  end

  typedef struct {
    logic [7:0] z;
    int         lat;
    int         t0;
    bit         tula;
    bit         shf;
    bit         err;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit seen_shf = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  state_t st;
  assign st = state_t'(sif.state_dbg);

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (reset) seen_shf = 1'b0;
    else begin
      if (st == COMBINE) begin
        if (q.size() != 0)
          chk("tula_comb", 32'(sif.tula), 32'(q[0].tula));
      end else if (sif.busy) begin
        chk("tula_other", 32'(sif.tula), 32'd0);
      end
      if (st == SHIFT) seen_shf = 1'b1;
      if (sif.done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("z", 32'(zm), 32'(e.z));
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("shift_seen", 32'(seen_shf), 32'(e.shf));
          chk("busy_done", 32'(sif.busy), 32'd0);
`ifdef SEQ_OPCODE_ERR_EN
          chk("err", 32'(sif.err), 32'(e.err));
`endif
        end
        seen_shf = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock); #1;
      n++;
    end while (st != IDLE && n < 50);
    if (st != IDLE) chk("idle_timeout", 32'(st), 32'(IDLE));
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input bit noisy);
    exp_t e;
    int n;
    wait_idle();
    e.tula = 1'b0; e.shf = 1'b0; e.err = 1'b0;
    case (int'(op))
      OP_ADD:  begin e.z = a + b; e.lat = 5; end
      OP_SUB:  begin e.z = a - b; e.lat = 5; e.tula = 1'b1; end
      OP_AVG:  begin e.z = a + b; e.z = e.z >> 1;
                     e.lat = 6; e.shf = 1'b1; end
      OP_MOVE: begin e.z = a; e.lat = 4; end
      default: begin
`ifdef SEQ_OPCODE_ERR_EN
        e.z = zm; e.lat = 1; e.err = 1'b1;
`else
        e.z = a + b; e.lat = 5;
`endif
      end
    endcase
    e.t0 = cyc;
    opa = a; opb = b;
    sif.opcode = op;
    sif.start  = 1'b1;
    q.push_back(e);
    @(negedge clock); #1;
    if (!noisy) sif.start = 1'b0;
    n = 0;
    while (!sif.done && n < 20) begin
      if (noisy) sif.opcode = 3'($urandom_range(7, 0));
      @(negedge clock); #1;
      n++;
    end
    if (!sif.done) chk("done_timeout", 32'd0, 32'd1);
    if (noisy) begin
      // start was high through the DONE edge; must not be queued.
      @(negedge clock); #1;
      chk("idle_after_done", 32'(st), 32'(IDLE));
      sif.start = 1'b0;
      @(negedge clock); #1;
      chk("start_not_queued", 32'(st), 32'(IDLE));
    end
  endtask

  initial begin
    int n;
    sif.start  = 1'b0;
    sif.opcode = 3'd0;
    opa = 8'd0; opb = 8'd0;
    #1;
    chk("rst_state", 32'(st), 32'(RST_CLR));
    chk("rst_tx", 32'(sif.tx), 32'(CLEAR));
    chk("rst_busy", 32'(sif.busy), 32'd1);
    chk("rst_done", 32'(sif.done), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rel_state", 32'(st), 32'(RST_CLR));
    @(negedge clock); #1;
    chk("idle_state", 32'(st), 32'(IDLE));
    chk("idle_tz", 32'(sif.tz), 32'(HOLD));
    chk("idle_busy", 32'(sif.busy), 32'd0);
    chk("z_cleared", 32'(zm), 32'd0);

    run_op(3'(OP_ADD), 8'd5, 8'd3, 1'b0);
    run_op(3'(OP_SUB), 8'd9, 8'd4, 1'b0);
    run_op(3'(OP_AVG), 8'd7, 8'd9, 1'b0);
    run_op(3'(OP_MOVE), 8'h0A, 8'h03, 1'b0);
    run_op(3'(OP_ADD), 8'd1, 8'd2, 1'b1);
    run_op(3'd6, 8'd1, 8'd2, 1'b0);
    run_op(3'(OP_ADD), 8'd10, 8'd20, 1'b0);

    // Abort an AVG in COMBINE with an asynchronous reset.
    wait_idle();
    opa = 8'd7; opb = 8'd9;
    sif.opcode = 3'(OP_AVG);
    sif.start  = 1'b1;
    @(negedge clock); #1;
    sif.start = 1'b0;
    n = 0;
    while (st != COMBINE && n < 10) begin
      @(negedge clock); #1;
      n++;
    end
    chk("reach_combine", 32'(st), 32'(COMBINE));
    #2 reset = 1'b1;
    #1;
    chk("abort_state", 32'(st), 32'(RST_CLR));
    chk("abort_ty", 32'(sif.ty), 32'(CLEAR));
    chk("abort_busy", 32'(sif.busy), 32'd1);
    chk("abort_done", 32'(sif.done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_rst_clr", 32'(st), 32'(RST_CLR));
    chk("abort_z_clr", 32'(zm), 32'd0);
    run_op(3'(OP_ADD), 8'd2, 8'd2, 1'b0);

    repeat (3) @(negedge clock);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Microprogrammed controller for the X/Y/Z/ULA arithmetic datapath, where X is the bus, Y the accumulator and Z the output register.
- Accepts a one-cycle start with a 3-bit opcode and walks a fixed state sequence.
- Drives per-register control codes (tx/ty/tz), ULA function (tula) and operand select, then pulses done.
- Sits between the host/top-level and the datapath; replaces free-running step counting with a start/busy/done handshake.

Parameters:
- CW, 4, width of each control-code output (tx, ty, tz, tula).
- OPW, 3, opcode width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- opcode  in  OPW  operation: 0 ADD, 1 SUB, 2 AVG, 3 MOVE, 4-7 illegal.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse in DONE.
- in_sel  out  1  datapath input mux select: 0 = operand A, 1 = operand B.
- tx  out  CW  X (bus) control code.
- ty  out  CW  Y (accumulator) control code.
- tz  out  CW  Z (output) control code.
- tula  out  CW  ULA function: 0 ADD, 1 SUB.
- state_dbg  out  4  current state encoding.

Behaviour:
- Control codes: CLEAR=0, LOAD=1, HOLD=2, SHIFTR=3. Y LOAD means Y <= Y (tula) X.
- Outputs are Moore-decoded from the registered state; no output depends combinationally on inputs.
- Reset (asynchronous): state=RST_CLR, opcode register=0. Outputs follow immediately: tx=ty=tz=CLEAR, tula=0, in_sel=0, busy=1, done=0.
- RST_CLR: all CLEAR, busy=1; always goes to IDLE next cycle.
- IDLE:
  - tx=ty=tz=HOLD, busy=0; Z holds the last result.
  - start=1 latches opcode and goes to FETCH_A.
- FETCH_A: tx=LOAD, in_sel=0, ty=CLEAR, tz=HOLD, tula=0 → LOAD_A.
- LOAD_A: tx=LOAD, in_sel=1, ty=LOAD, tula=0, so Y=A.
  - MOVE → STORE.
  - Otherwise → COMBINE.
- COMBINE: tx=HOLD, ty=LOAD, tula=1 for SUB else 0.
  - AVG → SHIFT.
  - Otherwise → STORE.
- SHIFT: tx=HOLD, ty=SHIFTR → STORE.
- STORE: tx=CLEAR, ty=HOLD, tz=LOAD → DONE.
- DONE: all HOLD, done=1, busy=0 → IDLE.
- start in DONE or any busy state is ignored and not queued; opcode changes while busy have no effect.
- Cycle count from the start-sampling edge to the done-high cycle:
  - MOVE: 4.
  - ADD/SUB: 5.
  - AVG: 6.
- Earliest back-to-back start is sampled in the IDLE cycle after DONE.
- Arithmetic width and overflow are owned by the datapath; the sequencer only selects codes.
- Unused state encodings recover to RST_CLR on the next edge.
- Reset mid-operation aborts immediately with no done pulse, and the datapath is cleared via RST_CLR.

Optional Feature:
SEQ_OPCODE_ERR_EN
- Defined:
  - Adds output err (1 bit, reset 0).
  - An illegal opcode (4-7) with start in IDLE goes to DONE directly with err=1 for that cycle.
  - No datapath register is modified (all HOLD); done still pulses.
- Undefined:
  - Illegal opcodes execute as ADD.
  - No err port exists.

Decomposition:
- Package seq_pkg holds:
  - Control-code constants CLEAR/LOAD/HOLD/SHIFTR.
  - ULA codes ULA_ADD/ULA_SUB.
  - Opcode constants OP_ADD/OP_SUB/OP_AVG/OP_MOVE.
  - State typedef with RST_CLR, IDLE, FETCH_A, LOAD_A, COMBINE, SHIFT, STORE, DONE.
- One sub-module, seq_decode: purely combinational state+opcode → {tx, ty, tz, tula, in_sel, busy, done}.
- The top holds the state and opcode registers and the next-state logic.

Test Plan:
- Reset asserted mid-cycle → outputs CLEAR immediately, busy=1. After release: one RST_CLR cycle, then IDLE with tx=ty=tz=HOLD, busy=0.
- ADD, start with A=5, B=3 on a model datapath → sequence FETCH_A, LOAD_A, COMBINE, STORE, DONE; done high 5 cycles after sampling; Z=8.
- SUB A=9, B=4 → tula=1 only in COMBINE, Z=5. AVG A=7, B=9 → SHIFT visited, Z=8, done at cycle 6.
- MOVE A=0xA → COMBINE skipped, Z=0xA, done at cycle 4. Start pulsed during busy and in DONE → ignored, exactly one done per accepted start.
- Reset asserted during COMBINE of AVG → no done pulse; Z cleared via RST_CLR; next ADD 2+2 gives Z=4.
- With SEQ_OPCODE_ERR_EN, opcode=6 → err=done=1 one cycle after sampling, Z unchanged. Without the macro → executes as ADD.
